aes_byte_loader: RTL
====================

// Module: aes_byte_loader
// PURPOSE
// Byte-stream front/back end for the combinational aesencrypt core.
// Assembles a 128-bit key and a 128-bit plaintext from a tagged 8-bit valid/ready input stream.
// Holds both stable on aes_datain/aes_key while the core settles, then latches aes_dataout.
// Streams the 16 ciphertext bytes out on a valid/ready port.
// Sits directly upstream of aesencrypt (drives datain, key) and downstream of it (consumes dataout).
// PARAMETERS
// SETTLE_CYCLES  2  clocks held in WAIT before aes_dataout is sampled (>=1; covers the core's comb path)
// PORTS
// clk          in   1    single clock, all flops rising-edge
// rst          in   1    asynchronous, active-high reset
// in_data      in   8    input byte
// in_key       in   1    1: byte belongs to the key; 0: byte belongs to the plaintext
// in_valid     in   1    in_data/in_key valid
// in_ready     out  1    loader accepts the byte this cycle (transfer = in_valid & in_ready)
// aes_datain   out  128  plaintext register to the core
// aes_key      out  128  key register to the core
// aes_dataout  in   128  ciphertext from the core
// out_data     out  8    ciphertext byte
// out_valid    out  1    out_data valid
// out_ready    in   1    sink accepts (transfer = out_valid & out_ready)
// busy         out  1    high in WAIT and SEND
// err          out  1    sticky: plaintext block completed with no key loaded
// BEHAVIOUR
// Reset: state=LOAD; kcnt=dcnt=ocnt=0; key_ok=0; aes_datain=aes_key=0; ct_reg=0.
// Reset outputs: in_ready=1, out_valid=0, out_data=0, busy=0, err=0.
// Reset mid-operation aborts immediately and discards partial key, data and ciphertext.
// Byte order is big-endian: the first byte of a group lands in [127:120], the 16th in [7:0].
// Counters kcnt, dcnt and ocnt are 4 bits each.
// LOAD: in_ready=1.
// - Key byte accepted: writes aes_key[127-8*kcnt -: 8]; kcnt++ with wrap 15->0.
// - At the wrap, key_ok<=1 (set on the cycle the 16th key byte is accepted).
// - Plaintext byte accepted: writes aes_datain[127-8*dcnt -: 8]; dcnt++.
// - On the 16th plaintext byte with key_ok=1: dcnt<=0, go WAIT with settle counter=SETTLE_CYCLES-1.
// - On the 16th plaintext byte with key_ok=0: err<=1, dcnt<=0, stay LOAD (block dropped).
// - Key and plaintext bytes may interleave freely.
// - A partial key being reloaded keeps key_ok at its old value until the wrap.
// - The key persists across blocks; a new key needs all 16 bytes.
// WAIT: in_ready=0; aes_datain and aes_key are held stable.
// - The settle counter decrements each clock.
// - At 0: ct_reg<=aes_dataout, ocnt<=0, go SEND.
// - Latency from the 16th plaintext accept to the first out_valid = SETTLE_CYCLES+1 clocks.
// SEND: in_ready=0; out_valid=1; out_data=ct_reg[127-8*ocnt -: 8] (registered, no comb path from in_*).
// - On each transfer ocnt++.
// - On the 16th transfer: out_valid=0 the next cycle, go LOAD.
// - out_ready low stalls: out_data is held and ocnt is unchanged.
// - A byte offered on in_* during WAIT/SEND is not taken; the source holds it (in_ready=0).
// busy = (state==WAIT)|(state==SEND). err clears only on rst.
// The core is purely combinational; the loader never relies on aes_dataout outside the WAIT sample cycle.
// TESTING
// 1 Load key bytes f1,fc,7f,1f,c7,... (f1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1), then plaintext aaeabaaeabaaeabaaeabaaeabaaeabaa
//   -> aes_key/aes_datain equal those words; 16 out bytes equal the model ciphertext, first byte = model[127:120].
// 2 Reset, send 16 plaintext bytes with no key -> err=1, no out_valid, state stays LOAD, in_ready=1.
// 3 Interleave key/plaintext bytes (k,d,k,d,...) -> same registers and ciphertext as scenario 1.
// 4 SETTLE_CYCLES=2, 16th plaintext accepted at cycle N -> first out_valid at N+3; in_ready=0 from N+1 until the last out transfer.
// 5 Toggle out_ready randomly (including held low for 5 clks) -> exactly 16 bytes out, in order, none duplicated.
// 6 Assert rst at out byte 7, then send a second block without reloading the key -> key_ok=0, err=1, and no bytes from the first block reappear.

Source files
------------

// File: rtl/aes_byte_loader.sv
// Byte-stream loader/unloader around the combinational aesencrypt core: bytes in, 16 ciphertext bytes out.
// First out_valid comes SETTLE_CYCLES+1 clocks after the 16th plaintext byte; in_ready is low in WAIT/SEND and out_ready stalls SEND.
module aes_byte_loader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] aes_datain,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_dataout,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_WAIT,
        S_SEND
    } state_t;

    state_t         state_q;
    logic [3:0]     kcnt_q;
    logic [3:0]     dcnt_q;
    logic [3:0]     ocnt_q;
    logic           key_ok_q;
    logic           err_q;
    logic [SW-1:0]  settle_q;
    logic [127:0]   key_q;
    logic [127:0]   dat_q;
    logic [127:0]   ct_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOAD;
            kcnt_q   <= 4'd0;
            dcnt_q   <= 4'd0;
            ocnt_q   <= 4'd0;
            key_ok_q <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= '0;
            key_q    <= '0;
            dat_q    <= '0;
            ct_q     <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // {~cnt,3'b111} is the MSB index 127-8*cnt of the byte slot.
                    if (in_valid && in_key) begin
                        key_q[{~kcnt_q, 3'b111} -: 8] <= in_data;
                        kcnt_q <= kcnt_q + 4'd1;
                        if (kcnt_q == 4'd15) begin
                            key_ok_q <= 1'b1;
                        end
                    end else if (in_valid) begin
                        dat_q[{~dcnt_q, 3'b111} -: 8] <= in_data;
                        dcnt_q <= dcnt_q + 4'd1;
                        if (dcnt_q == 4'd15) begin
                            if (key_ok_q) begin
                                state_q  <= S_WAIT;
                                settle_q <= SW'(SETTLE_CYCLES - 1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (settle_q == '0) begin
                        ct_q    <= aes_dataout;
                        ocnt_q  <= 4'd0;
                        state_q <= S_SEND;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                S_SEND: begin
                    // Shifting keeps the current byte in a fixed register slot.
                    if (out_ready) begin
                        ct_q   <= {ct_q[119:0], 8'h00};
                        ocnt_q <= ocnt_q + 4'd1;
                        if (ocnt_q == 4'd15) begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_SEND);
    assign busy       = (state_q == S_WAIT) || (state_q == S_SEND);
    assign out_data   = ct_q[127:120];
    assign aes_datain = dat_q;
    assign aes_key    = key_q;
    assign err        = err_q;

endmodule
